// File: rtl/poly_moment_acc.sv
// Streaming accumulator of polynomial least-squares moments: S_k = sum x^k (k=0..2*DEG)
// and T_k = sum x^k*y (k=0..DEG) over one batch of N_SAMPLES (x, y) pairs.
module poly_moment_acc #(
    parameter int XW        = 12,
    parameter int YW        = 16,
    parameter int DEG       = 2,
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [XW-1:0]                  x_in,
    input  logic [YW-1:0]                  y_in,
    output logic                           busy,
    output logic                           out_valid,
    output logic [(2*DEG+1)*ACC_W-1:0]     sxx,
    output logic [(DEG+1)*ACC_W-1:0]       sxy
);

    localparam int NS     = 2 * DEG + 1;
    localparam int NT     = DEG + 1;
    localparam int CW     = $clog2(N_SAMPLES + 1);
    localparam int FULL_W = 2 * DEG * XW + YW;
    // Products are formed at least as wide as the exact result so truncation to a lane is
    // the only rounding; a narrower lane simply wraps modulo 2^ACC_W.
    localparam int FW     = (FULL_W > ACC_W) ? FULL_W : ACC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              v_q, v_d;
    logic [ACC_W-1:0]  sxx_q [NS];
    logic [ACC_W-1:0]  sxx_d [NS];
    logic [ACC_W-1:0]  sxy_q [NT];
    logic [ACC_W-1:0]  sxy_d [NT];
    logic [FW-1:0]     pow_s [NS];
    logic [FW-1:0]     prod_s [NT];
    logic              clear_s;

    // Full-precision powers of the registered sample and their products with signed y.
    always_comb begin
        logic [FW-1:0] p;
        logic [FW-1:0] y_ext;
        p     = {{(FW-1){1'b0}}, 1'b1};
        y_ext = {{(FW-YW){y_q[YW-1]}}, y_q};
        for (int k = 0; k < NS; k++) begin
            pow_s[k] = p;
            p        = p * FW'(x_q);
        end
        for (int k = 0; k < NT; k++) begin
            prod_s[k] = pow_s[k] * y_ext;
        end
    end

    // Batch control, input stage and lane update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        v_d     = 1'b0;
        sxx_d   = sxx_q;
        sxy_d   = sxy_q;
        clear_s = 1'b0;

        if (v_q) begin
            for (int k = 0; k < NS; k++) begin
                sxx_d[k] = sxx_q[k] + pow_s[k][ACC_W-1:0];
            end
            for (int k = 0; k < NT; k++) begin
                sxy_d[k] = sxy_q[k] + prod_s[k][ACC_W-1:0];
            end
        end else begin
            sxx_d = sxx_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (abort) begin
                    state_d = IDLE;
                    clear_s = 1'b1;
                end else if (in_valid) begin
                    x_d   = x_in;
                    y_d   = y_in;
                    v_d   = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(N_SAMPLES - 1)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                clear_s = 1'b1;
            end
        endcase

        if (clear_s) begin
            cnt_d = '0;
            v_d   = 1'b0;
            for (int k = 0; k < NS; k++) begin
                sxx_d[k] = '0;
            end
            for (int k = 0; k < NT; k++) begin
                sxy_d[k] = '0;
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, input stage and accumulator lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            v_q     <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                sxx_q[k] <= '0;
            end
            for (int k = 0; k < NT; k++) begin
                sxy_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            v_q     <= v_d;
            sxx_q   <= sxx_d;
            sxy_q   <= sxy_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign busy      = (state_q == ACC) || (state_q == DRAIN);
    assign out_valid = (state_q == DONE);

    for (genvar k = 0; k < NS; k++) begin : g_sxx
        assign sxx[k*ACC_W +: ACC_W] = sxx_q[k];
    end
    for (genvar k = 0; k < NT; k++) begin : g_sxy
        assign sxy[k*ACC_W +: ACC_W] = sxy_q[k];
    end

endmodule

// File: tb/tb_poly_moment_acc.sv
// Bench for poly_moment_acc: a small DEG=2/N=4 instance checked every cycle against a
// batch-level model, plus a default-size instance checked on the full-scale corner.
module tb_poly_moment_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [11:0]   x_in = '0;
    logic [15:0]   y_in = '0;
    logic          in_ready, busy, out_valid;
    logic [319:0]  sxx;
    logic [191:0]  sxy;

    logic          b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
    logic [11:0]   b_x = '0;
    logic [15:0]   b_y = '0;
    logic          b_ready, b_busy, b_ov;
    logic [319:0]  b_sxx;
    logic [191:0]  b_sxy;

    poly_moment_acc #(.XW(12), .YW(16), .DEG(2), .N_SAMPLES(4), .ACC_W(64)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .x_in(x_in), .y_in(y_in), .busy(busy), .out_valid(out_valid),
        .sxx(sxx), .sxy(sxy)
    );

    poly_moment_acc u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .in_valid(b_valid),
        .in_ready(b_ready), .x_in(b_x), .y_in(b_y), .busy(b_busy), .out_valid(b_ov),
        .sxx(b_sxx), .sxy(b_sxy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Batch-level model of the small instance: phase 0 idle, 1 collecting, 2 last commit, 3 done.
    int     mph = 0;
    longint exp_s [5];
    longint exp_t [3];
    int     qx [$];
    int     qy [$];

    function automatic void zero_exp();
        for (int k = 0; k < 5; k++) exp_s[k] = 0;
        for (int k = 0; k < 3; k++) exp_t[k] = 0;
    endfunction

    function automatic void compute_sums();
        for (int k = 0; k < 5; k++) begin
            longint s = 0;
            for (int i = 0; i < qx.size(); i++) begin
                longint p = 1;
                for (int j = 0; j < k; j++) p = p * qx[i];
                s = s + p;
                if (k < 3) exp_t[k] = exp_t[k] + p * qy[i];
            end
            exp_s[k] = s;
        end
    endfunction

    initial begin
        zero_exp();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mph = 0;
                zero_exp();
                qx.delete();
                qy.delete();
            end else begin
                case (mph)
                    0: if (start) begin
                        mph = 1;
                        qx.delete();
                        qy.delete();
                    end
                    1: if (abort) begin
                        mph = 0;
                        zero_exp();
                    end else if (in_valid) begin
                        qx.push_back(int'(x_in));
                        qy.push_back(int'($signed(y_in)));
                        if (qx.size() == 4) mph = 2;
                    end
                    2: if (abort) begin
                        mph = 0;
                        zero_exp();
                    end else begin
                        mph = 3;
                        zero_exp();
                        compute_sums();
                    end
                    default: mph = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison of the small instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk1("in_ready", in_ready, mph == 1);
            chk1("busy", busy, (mph == 1) || (mph == 2));
            chk1("out_valid", out_valid, mph == 3);
            if (mph == 0 || mph == 3) begin
                for (int k = 0; k < 5; k++) chk64("model_sxx", sxx[k*64 +: 64], exp_s[k]);
                for (int k = 0; k < 3; k++) chk64("model_sxy", sxy[k*64 +: 64], exp_t[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_batch(input int yv, input bit gaps, input bit start_mid);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            x_in = 12'(i + 1);
            y_in = 16'(yv);
            if (start_mid && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit big, output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((big ? b_ov : out_valid) == 1'b1) begin
                lat = c;
                break;
            end
        end
        n_chk++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL done_latency: got %0d cycles expected 2 (0 = timeout)", lat);
        end
    endtask

    task automatic check_pos_batch();
        logic [63:0] es [5];
        logic [63:0] et [3];
        es = '{64'd4, 64'd10, 64'd30, 64'd100, 64'd354};
        et = '{64'd4, 64'd10, 64'd30};
        for (int k = 0; k < 5; k++) chk64("lit_sxx", sxx[k*64 +: 64], es[k]);
        for (int k = 0; k < 3; k++) chk64("lit_sxy", sxy[k*64 +: 64], et[k]);
    endtask

    int lat;

    initial begin
        logic [63:0] en [3];
        longint x4, e_s4, e_t2;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b0);
        chk64("reset_s0", sxx[63:0], 64'd0);
        rst_n = 1'b1;
        tick();

        // y = +1, back to back
        run_batch(1, 1'b0, 1'b0);
        wait_done(1'b0, lat);
        check_pos_batch();
        tick();

        // y = -1
        run_batch(-1, 1'b0, 1'b0);
        wait_done(1'b0, lat);
        en = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFE2};
        chk64("neg_s4", sxx[4*64 +: 64], 64'd354);
        for (int k = 0; k < 3; k++) chk64("neg_sxy", sxy[k*64 +: 64], en[k]);
        tick();

        // gaps in in_valid
        run_batch(1, 1'b1, 1'b0);
        wait_done(1'b0, lat);
        check_pos_batch();
        tick();

        // abort after two samples
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x_in = 12'(i + 1);
            y_in = 16'd1;
            tick();
        end
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk64("abort_s1", sxx[64 +: 64], 64'd0);
        chk64("abort_t0", sxy[0 +: 64], 64'd0);
        repeat (3) tick();
        run_batch(1, 1'b0, 1'b0);
        wait_done(1'b0, lat);
        check_pos_batch();
        tick();

        // reset mid-batch
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        x_in = 12'd3;
        y_in = 16'd5;
        repeat (2) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk64("rst_s2", sxx[2*64 +: 64], 64'd0);
        chk64("rst_t1", sxy[64 +: 64], 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // start during ACC ignored, then start during DONE ignored
        run_batch(1, 1'b0, 1'b1);
        wait_done(1'b0, lat);
        check_pos_batch();
        #1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk1("done_start_busy", busy, 1'b0);
        chk64("done_start_hold_s4", sxx[4*64 +: 64], 64'd354);

        // full-scale corner on the default-size instance
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        b_x = 12'd4095;
        b_y = 16'h8000;
        repeat (256) tick();
        b_valid = 1'b0;
        wait_done(1'b1, lat);
        x4 = 64'd4095;
        x4 = x4 * x4 * x4 * x4;
        e_s4 = 64'd256 * x4;
        e_t2 = -(64'd256 * 64'd4095 * 64'd4095 * 64'd32768);
        chk64("big_s0", b_sxx[0 +: 64], 64'd256);
        chk64("big_s1", b_sxx[64 +: 64], 64'd1048320);
        chk64("big_s4", b_sxx[4*64 +: 64], e_s4);
        chk64("big_s4_lit", b_sxx[4*64 +: 64], 64'd71987251059360000);
        chk64("big_t0", b_sxy[0 +: 64], -64'd8388608);
        chk64("big_t2", b_sxy[2*64 +: 64], e_t2);
        tick();
        chk1("big_idle", b_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
